alarm_controller: RTL and testbench
===================================

// Module: alarm_controller
// PURPOSE
//  Downstream stage of the time-of-day counter. Consumes the hours/minutes/seconds
//  it produces plus the user alarm setting. Detects the alarm instant, then runs a
//  ring/snooze/stop state machine that drives a pulsed buzzer. Auto-silences after
//  a timeout and limits the number of snoozes.
// PARAMETERS
//  SNOOZE_MIN      5   minutes added to the current time on a snooze (1..59)
//  RING_TIMEOUT_S  60  tick_1hz periods of ringing before auto-stop (>=2)
//  MAX_SNOOZE      3   snoozes allowed per alarm event (1..7)
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  reset          in   1  synchronous, active-high
//  tick_1hz       in   1  one-clk pulse per second, aligned with seconds update
//  hours          in   5  current hour 0..23
//  minutes        in   6  current minute 0..59
//  seconds        in   6  current second 0..59
//  alarm_hours    in   5  alarm hour 0..23
//  alarm_minutes  in   6  alarm minute 0..59
//  alarm_enable   in   1  level; 0 disables and cancels any ring/snooze
//  snooze_btn     in   1  one-clk pulse (debounced upstream)
//  stop_btn       in   1  one-clk pulse (debounced upstream)
//  buzzer         out  1  audible output, 1 Hz on/off pattern while ringing
//  ringing        out  1  1 while in RINGING
//  snoozing       out  1  1 while in SNOOZE
//  snooze_count   out  3  snoozes used in the current event
//  alarm_event    out  1  one-clk pulse on every RINGING entry
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0. armed=1, ring_cnt=0, beep_phase=0, target=0.
//  - States: IDLE, RINGING, SNOOZE. Outputs are registered.
//  - match(T) = alarm_enable & hours==T.h & minutes==T.m & seconds==0.
//  - IDLE: if match(alarm_hours/minutes) & armed, go to RINGING. Next cycle:
//    ringing=1, alarm_event=1 for one cycle, snooze_count=0, armed=0.
//  - armed returns to 1 when minutes != alarm_minutes. This stops a re-trigger within
//    the same minute after stop or timeout.
//  - RINGING entry (any source): ring_cnt=0, beep_phase=1. beep_phase toggles on
//    each tick_1hz. buzzer = ringing & beep_phase.
//  - RINGING: ring_cnt increments on tick_1hz.
//    - Priority: alarm_enable==0 > stop_btn > snooze_btn > timeout.
//    - alarm_enable==0 or stop_btn: go to IDLE.
//    - snooze_btn with snooze_count<MAX_SNOOZE: go to SNOOZE, snooze_count+1,
//      target = now + SNOOZE_MIN.
//    - snooze_btn with snooze_count==MAX_SNOOZE: ignored, keep ringing.
//    - tick_1hz with ring_cnt==RING_TIMEOUT_S-1: go to IDLE (auto-stop).
//  - Snooze target arithmetic:
//    - m = minutes + SNOOZE_MIN. If m>=60: m-=60 and h=hours+1.
//    - If h==24: h=0. Carries across 23:59 -> 00:0x.
//  - SNOOZE:
//    - alarm_enable==0 or stop_btn: go to IDLE, snooze_count=0.
//    - match(target): go to RINGING, alarm_event pulses, snooze_count held.
//    - Changes to alarm_hours/minutes do not affect target.
//    - snooze_btn is ignored.
//  - Output timing: state changes one clk after the qualifying input cycle. The
//    ringing/buzzer/snoozing outputs reflect the new state in that same cycle.
//  - Reset asserted mid-ring or mid-snooze: IDLE next clk, outputs 0.
// TESTING
//  - Alarm 08:00, enable=1. Count time to 08:00:00 -> ringing=1 one clk after;
//    alarm_event pulses once; buzzer toggles at each tick_1hz.
//  - Ring, no input -> RINGING_TIMEOUT_S=60 ticks later ringing=0, buzzer=0.
//    Same minute: no re-trigger.
//  - Alarm 23:57, SNOOZE_MIN=5. Snooze at 23:57:10 -> snoozing=1, re-ring at
//    00:02:00, snooze_count=1.
//  - Snooze 3 times (MAX_SNOOZE=3); 4th snooze_btn -> still ringing.
//    Then stop_btn -> IDLE, snooze_count=0.
//  - Same cycle snooze_btn & stop_btn while ringing -> IDLE (stop wins).
//    alarm_enable=0 during SNOOZE -> IDLE, no later ring.
//  - Reset pulse while ringing -> all outputs 0 next clk. Alarm re-fires the next
//    day at 08:00:00.

Source files
------------

// File: rtl/alarm_controller.sv
// alarm_controller: detects the alarm instant and runs the ring/snooze/stop FSM driving a 1 Hz pulsed buzzer
module alarm_controller #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       alarm_enable,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_count,
    output logic       alarm_event
);
    localparam int CW = $clog2(RING_TIMEOUT_S);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    state_t        r_state;
    logic          r_armed;
    logic          r_beep;
    logic [CW-1:0] r_ring_cnt;
    logic [4:0]    r_tgt_h;
    logic [5:0]    r_tgt_m;
    logic          r_buzzer;
    logic          r_ringing;
    logic          r_snoozing;
    logic          r_event;
    logic [2:0]    r_snooze_count;

    logic       w_alarm_match;
    logic       w_tgt_match;
    logic       w_timeout;
    logic       w_can_snooze;
    logic       w_cancel;
    logic       w_exit;
    logic       w_enter;
    logic       w_snooze;
    logic       w_wrap;
    logic [6:0] w_m_sum;
    logic [5:0] w_snz_m;
    logic [4:0] w_snz_h;

    assign w_alarm_match = alarm_enable && hours == alarm_hours && minutes == alarm_minutes && seconds == 6'd0;
    assign w_tgt_match   = alarm_enable && hours == r_tgt_h && minutes == r_tgt_m && seconds == 6'd0;
    assign w_timeout     = tick_1hz && r_ring_cnt == CW'(RING_TIMEOUT_S - 1);
    assign w_can_snooze  = snooze_btn && r_snooze_count < 3'(MAX_SNOOZE);
    assign w_cancel      = !alarm_enable || stop_btn;

    // Exit beats snooze, snooze beats the auto-stop timeout
    assign w_exit   = (r_state != IDLE) && (w_cancel || (r_state == RINGING && !w_can_snooze && w_timeout));
    assign w_snooze = r_state == RINGING && !w_cancel && w_can_snooze;
    assign w_enter  = (r_state == IDLE && w_alarm_match && r_armed) ||
                      (r_state == SNOOZE && !w_cancel && w_tgt_match);

    assign w_m_sum = {1'b0, minutes} + 7'(SNOOZE_MIN);
    assign w_wrap  = w_m_sum >= 7'd60;
    assign w_snz_m = w_wrap ? 6'(w_m_sum - 7'd60) : w_m_sum[5:0];
    assign w_snz_h = !w_wrap ? hours : (hours == 5'd23 ? 5'd0 : hours + 5'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_armed        <= 1'b1;
            r_beep         <= 1'b0;
            r_ring_cnt     <= '0;
            r_tgt_h        <= '0;
            r_tgt_m        <= '0;
            r_buzzer       <= 1'b0;
            r_ringing      <= 1'b0;
            r_snoozing     <= 1'b0;
            r_event        <= 1'b0;
            r_snooze_count <= '0;
        end else begin
            r_event <= 1'b0;
            if (minutes != alarm_minutes) r_armed <= 1'b1;
            if (w_exit) begin
                r_state        <= IDLE;
                r_ringing      <= 1'b0;
                r_snoozing     <= 1'b0;
                r_buzzer       <= 1'b0;
                r_snooze_count <= '0;
            end else if (w_enter) begin
                r_state    <= RINGING;
                r_ringing  <= 1'b1;
                r_snoozing <= 1'b0;
                r_buzzer   <= 1'b1;
                r_beep     <= 1'b1;
                r_ring_cnt <= '0;
                r_event    <= 1'b1;
                // A fresh alarm event (not a snooze re-ring) restarts the count and disarms for this minute
                if (r_state == IDLE) begin
                    r_snooze_count <= '0;
                    r_armed        <= 1'b0;
                end
            end else if (w_snooze) begin
                r_state        <= SNOOZE;
                r_ringing      <= 1'b0;
                r_snoozing     <= 1'b1;
                r_buzzer       <= 1'b0;
                r_snooze_count <= r_snooze_count + 3'd1;
                r_tgt_h        <= w_snz_h;
                r_tgt_m        <= w_snz_m;
            end else if (r_state == RINGING && tick_1hz) begin
                r_ring_cnt <= r_ring_cnt + CW'(1);
                r_beep     <= ~r_beep;
                r_buzzer   <= ~r_beep;
            end
        end
    end

    assign buzzer       = r_buzzer;
    assign ringing      = r_ringing;
    assign snoozing     = r_snoozing;
    assign snooze_count = r_snooze_count;
    assign alarm_event  = r_event;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed scenarios plus a random soak against a minute-of-day reference model
module tb_alarm_controller;
    localparam int SNOOZE_MIN     = 5;
    localparam int RING_TIMEOUT_S = 60;
    localparam int MAX_SNOOZE     = 3;

    logic       clk = 1'b0;
    logic       reset, tick_1hz, alarm_enable, snooze_btn, stop_btn;
    logic [4:0] hours, alarm_hours;
    logic [5:0] minutes, seconds, alarm_minutes;
    logic       buzzer, ringing, snoozing, alarm_event;
    logic [2:0] snooze_count;
    logic [6:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0=idle 1=ringing 2=snoozing, target kept as minute of day
    int m_mode = 0, m_ticks = 0, m_cnt = 0, m_tgt = 0;
    bit m_armed = 1'b1, m_event = 1'b0;

    // obs layout: {ringing, snoozing, buzzer, alarm_event, snooze_count[2:0]}
    assign obs = {ringing, snoozing, buzzer, alarm_event, snooze_count};

    always #5 clk = ~clk;

    alarm_controller #(
        .SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_S(RING_TIMEOUT_S), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .hours(hours), .minutes(minutes),
        .seconds(seconds), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .alarm_enable(alarm_enable), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
        .snooze_count(snooze_count), .alarm_event(alarm_event)
    );

    task automatic model_step();
        int  now;
        bit  sec0, new_armed;
        if (reset) begin
            m_mode = 0; m_armed = 1'b1; m_ticks = 0; m_cnt = 0; m_tgt = 0; m_event = 1'b0;
        end else begin
            now       = int'(hours) * 60 + int'(minutes);
            sec0      = (seconds == 6'd0);
            new_armed = (minutes != alarm_minutes) ? 1'b1 : m_armed;
            m_event   = 1'b0;
            if (m_mode == 0) begin
                if (alarm_enable && sec0 && m_armed && now == int'(alarm_hours) * 60 + int'(alarm_minutes)) begin
                    m_mode = 1; m_ticks = 0; m_cnt = 0; m_event = 1'b1; new_armed = 1'b0;
                end
            end else if (!alarm_enable || stop_btn) begin
                m_mode = 0; m_cnt = 0;
            end else if (m_mode == 1) begin
                if (snooze_btn && m_cnt < MAX_SNOOZE) begin
                    m_mode = 2; m_cnt++; m_tgt = (now + SNOOZE_MIN) % 1440;
                end else if (tick_1hz) begin
                    m_ticks++;
                    if (m_ticks == RING_TIMEOUT_S) begin m_mode = 0; m_cnt = 0; end
                end
            end else if (sec0 && now == m_tgt) begin
                m_mode = 1; m_ticks = 0; m_event = 1'b1;
            end
            m_armed = new_armed;
        end
    endtask

    function automatic logic [6:0] expv();
        return {m_mode == 1, m_mode == 2, m_mode == 1 && (m_ticks % 2 == 0), m_event, 3'(m_cnt)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        step();
        hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic tick_sec();
        int t;
        t = (int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds) + 1) % 86400;
        set_time(t / 3600, (t / 60) % 60, t % 60);
    endtask

    task automatic press(input bit snz, input bit stp);
        snooze_btn = snz; stop_btn = stp;
        step();
        snooze_btn = 1'b0; stop_btn = 1'b0;
    endtask

    task automatic do_reset();
        seconds = 6'd1; alarm_hours = 5'd8; alarm_minutes = 6'd0; alarm_enable = 1'b1;
        snooze_btn = 1'b0; stop_btn = 1'b0; tick_1hz = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick_1hz = 1'b0; alarm_enable = 1'b1; snooze_btn = 1'b0; stop_btn = 1'b0;
        hours = 5'd8; minutes = 6'd0; seconds = 6'd0; alarm_hours = 5'd8; alarm_minutes = 6'd0;
        repeat (3) step();
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL reset_hold: obs=%b exp=%b", obs, 7'b0000000); end
        press(1'b1, 1'b0);
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL reset_ignores_inputs: obs=%b exp=%b", obs, 7'b0000000); end
        reset = 1'b0;
        step();
        n_cmp++; if (obs !== 7'b1011000) begin n_err++; $display("FAIL reset_armed: obs=%b exp=%b", obs, 7'b1011000); end
    endtask

    task automatic test_alarm_fire();
        logic [6:0] e;
        do_reset();
        set_time(7, 59, 58);
        tick_sec();
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL pre_alarm: obs=%b exp=%b", obs, 7'b0000000); end
        tick_sec();
        n_cmp++; if (obs !== 7'b1011000) begin n_err++; $display("FAIL fire_entry: obs=%b exp=%b", obs, 7'b1011000); end
        step();
        n_cmp++; if (obs !== 7'b1010000) begin n_err++; $display("FAIL fire_event_once: obs=%b exp=%b", obs, 7'b1010000); end
        for (int k = 1; k <= 4; k++) begin
            tick_sec();
            e = {1'b1, 1'b0, k % 2 == 0, 1'b0, 3'd0};
            n_cmp++; if (obs !== e) begin n_err++; $display("FAIL buzz_toggle_%0d: obs=%b exp=%b", k, obs, e); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_time(8, 0, 0);
        repeat (RING_TIMEOUT_S - 1) tick_sec();
        n_cmp++; if (obs !== 7'b1000000) begin n_err++; $display("FAIL timeout_last_tick: obs=%b exp=%b", obs, 7'b1000000); end
        tick_sec();
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL timeout_stop: obs=%b exp=%b", obs, 7'b0000000); end
        do_reset();
        set_time(8, 0, 0);
        repeat ($urandom_range(1, 20)) tick_sec();
        press(1'b0, 1'b1);
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL stop_ring: obs=%b exp=%b", obs, 7'b0000000); end
        set_time(8, 0, 0);
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL no_retrigger: obs=%b exp=%b", obs, 7'b0000000); end
        set_time(8, 1, 30);
        set_time(8, 0, 0);
        n_cmp++; if (obs !== 7'b1011000) begin n_err++; $display("FAIL rearmed: obs=%b exp=%b", obs, 7'b1011000); end
    endtask

    task automatic test_snooze_wrap();
        do_reset();
        alarm_hours = 5'd23; alarm_minutes = 6'd57;
        set_time(23, 57, 0);
        n_cmp++; if (obs !== 7'b1011000) begin n_err++; $display("FAIL wrap_ring: obs=%b exp=%b", obs, 7'b1011000); end
        repeat (10) tick_sec();
        press(1'b1, 1'b0);
        n_cmp++; if (obs !== 7'b0100001) begin n_err++; $display("FAIL wrap_snooze: obs=%b exp=%b", obs, 7'b0100001); end
        alarm_hours = 5'd5; alarm_minutes = 6'd2;
        set_time(0, 1, 59);
        n_cmp++; if (obs !== 7'b0100001) begin n_err++; $display("FAIL wrap_wait: obs=%b exp=%b", obs, 7'b0100001); end
        tick_sec();
        n_cmp++; if (obs !== 7'b1011001) begin n_err++; $display("FAIL wrap_rering: obs=%b exp=%b", obs, 7'b1011001); end
    endtask

    task automatic test_max_snooze();
        logic [6:0] e;
        int t;
        do_reset();
        alarm_hours = 5'($urandom_range(0, 23)); alarm_minutes = 6'($urandom_range(0, 59));
        set_time(int'(alarm_hours), int'(alarm_minutes), 0);
        n_cmp++; if (obs !== 7'b1011000) begin n_err++; $display("FAIL max_first_ring: obs=%b exp=%b", obs, 7'b1011000); end
        for (int i = 1; i <= MAX_SNOOZE; i++) begin
            tick_sec();
            press(1'b1, 1'b0);
            e = {1'b0, 1'b1, 1'b0, 1'b0, 3'(i)};
            n_cmp++; if (obs !== e) begin n_err++; $display("FAIL max_snooze_%0d: obs=%b exp=%b", i, obs, e); end
            t = (int'(hours) * 60 + int'(minutes) + SNOOZE_MIN) % 1440;
            set_time(t / 60, t % 60, 0);
            e = {1'b1, 1'b0, 1'b1, 1'b1, 3'(i)};
            n_cmp++; if (obs !== e) begin n_err++; $display("FAIL max_rering_%0d: obs=%b exp=%b", i, obs, e); end
        end
        tick_sec();
        press(1'b1, 1'b0);
        n_cmp++; if (obs !== 7'b1000011) begin n_err++; $display("FAIL max_ignored: obs=%b exp=%b", obs, 7'b1000011); end
        press(1'b0, 1'b1);
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL max_stop: obs=%b exp=%b", obs, 7'b0000000); end
    endtask

    task automatic test_priority();
        do_reset();
        set_time(8, 0, 0);
        tick_sec();
        press(1'b1, 1'b1);
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL stop_wins: obs=%b exp=%b", obs, 7'b0000000); end
        set_time(8, 1, 0);
        set_time(8, 0, 0);
        alarm_enable = 1'b0;
        step();
        alarm_enable = 1'b1;
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL disable_ring: obs=%b exp=%b", obs, 7'b0000000); end
        set_time(8, 1, 0);
        set_time(8, 0, 0);
        tick_sec();
        press(1'b1, 1'b0);
        n_cmp++; if (obs !== 7'b0100001) begin n_err++; $display("FAIL prio_snooze: obs=%b exp=%b", obs, 7'b0100001); end
        alarm_enable = 1'b0;
        step();
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL disable_snooze: obs=%b exp=%b", obs, 7'b0000000); end
        alarm_enable = 1'b1;
        set_time(8, 5, 0);
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL no_late_ring: obs=%b exp=%b", obs, 7'b0000000); end
    endtask

    task automatic test_reset_mid_ring();
        do_reset();
        set_time(7, 59, 59);
        tick_sec();
        n_cmp++; if (obs !== 7'b1011000) begin n_err++; $display("FAIL day1_ring: obs=%b exp=%b", obs, 7'b1011000); end
        tick_sec();
        tick_sec();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (obs !== 7'b0000000) begin n_err++; $display("FAIL reset_mid_ring: obs=%b exp=%b", obs, 7'b0000000); end
        set_time(12, 0, 0);
        set_time(7, 59, 59);
        tick_sec();
        n_cmp++; if (obs !== 7'b1011000) begin n_err++; $display("FAIL day2_ring: obs=%b exp=%b", obs, 7'b1011000); end
    endtask

    task automatic test_random();
        logic [6:0] e;
        int r, t;
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) alarm_enable = ($urandom_range(0, 7) != 0);
            else if (r < 9) begin
                hours = alarm_hours; minutes = alarm_minutes; seconds = 6'd0; tick_1hz = 1'b1;
            end else if (r < 13) begin
                hours = 5'(m_tgt / 60); minutes = 6'(m_tgt % 60); seconds = 6'd0; tick_1hz = 1'b1;
            end else if (r < 15) reset = 1'b1;
            else if (r < 21) snooze_btn = 1'b1;
            else if (r < 25) begin stop_btn = 1'b1; snooze_btn = 1'($urandom_range(0, 1)); end
            else if (r < 27) begin
                alarm_hours = 5'($urandom_range(0, 23)); alarm_minutes = 6'($urandom_range(0, 59));
            end else if (r < 30) begin
                hours = 5'($urandom_range(0, 23)); minutes = 6'($urandom_range(0, 59));
                seconds = 6'($urandom_range(0, 59)); tick_1hz = 1'b1;
            end else if (r < 65) begin
                t = (int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds) + 1) % 86400;
                hours = 5'(t / 3600); minutes = 6'((t / 60) % 60); seconds = 6'(t % 60); tick_1hz = 1'b1;
            end
            step();
            e = expv();
            n_cmp++; if (obs !== e) begin n_err++; $display("FAIL random_%0d: obs=%b exp=%b", n, obs, e); end
            reset = 1'b0; tick_1hz = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alarm_fire();
        test_timeout();
        test_snooze_wrap();
        test_max_snooze();
        test_priority();
        test_reset_mid_ring();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
